// File: rtl/neural_network.sv
// ---------------------------------------------------------------------------
// neural_network
//   Two-layer fully connected integer perceptron (input -> hidden -> output).
//   Each neuron is a multiply-accumulate over a balanced adder tree.
//   The hidden layer applies a saturating ReLU. The output layer is linear
//   and saturates to WIDTH bits.
//   The pipeline accepts one vector per cycle and has a fixed latency of 2.
//
//   Optional build macro: MASK_EN
//     When defined, every product is split into two additive shares.
//     One share comes from a free-running 16-bit LFSR word. Each share vector
//     is reduced in its own tree, and the two sums are recombined modulo
//     2^ACC. Results and latency are unchanged.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   sample inputs / weights this cycle
//   inputs     x[i]     at [i*WIDTH +: WIDTH]
//   weights1   W1[j][k] at [(j*INPUT_SIZE+k)*WIDTH +: WIDTH]
//   weights2   W2[o][j] at [(o*HIDDEN_SIZE+j)*WIDTH +: WIDTH]
//   outputs    y[o]     at [o*WIDTH +: WIDTH], registered
//   out_valid  outputs carry a fresh result this cycle
// ---------------------------------------------------------------------------

// One neuron: dot product of a_i and b_i, then saturation.
// RELU=1 selects the hidden-layer clamp [0, 2^(W-1)-1].
// RELU=0 selects the signed clamp.
module nn_neuron #(
    parameter int N     = 10,
    parameter int WIDTH = 16,
    parameter bit RELU  = 1'b1
) (
`ifdef MASK_EN
    input  logic [15:0]               mask_i,
`endif
    input  logic [N-1:0][WIDTH-1:0]   a_i,
    input  logic [N-1:0][WIDTH-1:0]   b_i,
    output logic [WIDTH-1:0]          y_o
);
    // The accumulator is wide enough for N full-scale products, so the
    // modular tree sum equals the true sum.
    localparam int ACC = 2*WIDTH + $clog2(N);
    localparam int P   = 1 << $clog2(N);

    // Balanced binary reduction over a heap-ordered node array.
    // Leaves sit at P..2P-1 and the root is node 1.
    function automatic logic [ACC-1:0] tree_sum(input logic [P-1:0][ACC-1:0] leaf);
        logic [ACC-1:0] node [1:2*P-1];
        for (int n = 0; n < P; n++) node[P+n] = leaf[n];
        for (int n = P-1; n >= 1; n--) node[n] = node[2*n] + node[2*n+1];
        return node[1];
    endfunction

    logic [P-1:0][ACC-1:0] prod;
    logic [ACC-1:0]        acc;

    // Padding leaves stay zero.
    always_comb begin
        prod = '0;
        for (int i = 0; i < N; i++)
            prod[i] = ACC'($signed(a_i[i]) * $signed(b_i[i]));
    end

`ifdef MASK_EN
    logic [P-1:0][ACC-1:0] share0, share1;
    logic [15:0]           rot;

    // Share 0 is the LFSR word rotated by the product index, sign-extended.
    // Share 1 is p - r. Neither tree ever sees the bare products.
    always_comb begin
        share0 = '0;
        share1 = '0;
        rot    = '0;
        for (int i = 0; i < N; i++) begin
            rot       = (mask_i << (i % 16)) | (mask_i >> (16 - (i % 16)));
            share0[i] = ACC'($signed(rot));
            share1[i] = prod[i] - share0[i];
        end
    end

    assign acc = tree_sum(share0) + tree_sum(share1);
`else
    assign acc = tree_sum(prod);
`endif

    always_comb begin
        y_o = acc[WIDTH-1:0];
        if (RELU) begin
            if (acc[ACC-1])
                y_o = '0;
            else if (|acc[ACC-2:WIDTH-1])
                y_o = {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            // The value fits only if every bit from WIDTH-1 upward equals the sign bit.
            if (!((&acc[ACC-1:WIDTH-1]) || !(|acc[ACC-1:WIDTH-1])))
                y_o = acc[ACC-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
endmodule

module neural_network #(
    parameter int INPUT_SIZE  = 10,
    parameter int HIDDEN_SIZE = 10,
    parameter int OUTPUT_SIZE = 5,
    parameter int WIDTH       = 16
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      in_valid,
    input  logic [INPUT_SIZE*WIDTH-1:0]               inputs,
    input  logic [HIDDEN_SIZE*INPUT_SIZE*WIDTH-1:0]   weights1,
    input  logic [OUTPUT_SIZE*HIDDEN_SIZE*WIDTH-1:0]  weights2,
    output logic [OUTPUT_SIZE*WIDTH-1:0]              outputs,
    output logic                                      out_valid
);
    localparam int STAGES = 2;

    // Packed views. The bit layout matches the flat port layout exactly.
    logic [INPUT_SIZE-1:0][WIDTH-1:0]                  x;
    logic [HIDDEN_SIZE-1:0][INPUT_SIZE-1:0][WIDTH-1:0] w1;
    logic [HIDDEN_SIZE-1:0][WIDTH-1:0]                 h_d, h_q;
    logic [OUTPUT_SIZE-1:0][HIDDEN_SIZE-1:0][WIDTH-1:0] w2_q;
    logic [OUTPUT_SIZE-1:0][WIDTH-1:0]                 y_d, y_q;
    logic [STAGES:1]                                   vld_pipe_q;

    assign x  = inputs;
    assign w1 = weights1;

`ifdef MASK_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR with polynomial x^16+x^14+x^13+x^11+1. It shifts right and feeds back into the MSB.
    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end
`endif

    for (genvar j = 0; j < HIDDEN_SIZE; j++) begin : g_hid
        nn_neuron #(.N(INPUT_SIZE), .WIDTH(WIDTH), .RELU(1'b1)) u_neuron (
`ifdef MASK_EN
            .mask_i (lfsr_q),
`endif
            .a_i    (x),
            .b_i    (w1[j]),
            .y_o    (h_d[j])
        );
    end

    for (genvar o = 0; o < OUTPUT_SIZE; o++) begin : g_out
        nn_neuron #(.N(HIDDEN_SIZE), .WIDTH(WIDTH), .RELU(1'b0)) u_neuron (
`ifdef MASK_EN
            .mask_i (lfsr_q),
`endif
            .a_i    (h_q),
            .b_i    (w2_q[o]),
            .y_o    (y_d[o])
        );
    end

    // Stage 1 captures the hidden layer. It also captures W2, so that the
    // second stage uses the weights that arrived with the same vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q  <= '0;
            w2_q <= '0;
        end else if (in_valid) begin
            h_q  <= h_d;
            w2_q <= weights2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             y_q <= '0;
        else if (vld_pipe_q[1]) y_q <= y_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe_q <= '0;
        else        vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_valid};
    end

    assign outputs   = y_q;
    assign out_valid = vld_pipe_q[STAGES];
endmodule

// File: tb/tb_neural_network.sv
module tb_neural_network;
    localparam int IN  = 10;
    localparam int HID = 10;
    localparam int OUT = 5;
    localparam int W   = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic [IN*W-1:0]        inputs;
    logic [HID*IN*W-1:0]    weights1;
    logic [OUT*HID*W-1:0]   weights2;
    logic [OUT*W-1:0]       outputs;
    logic                   out_valid;

    always #5 clk = ~clk;

    neural_network #(.INPUT_SIZE(IN), .HIDDEN_SIZE(HID), .OUTPUT_SIZE(OUT), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .inputs    (inputs),
        .weights1  (weights1),
        .weights2  (weights2),
        .outputs   (outputs),
        .out_valid (out_valid)
    );

    // Stimulus held as plain integers
    int x  [IN];
    int w1 [HID][IN];
    int w2 [OUT][HID];

    // Scoreboard entries: the edge index after which the result is visible, and the expected value.
    typedef struct { int due; logic [OUT*W-1:0] y; } exp_t;
    exp_t             q[$];
    int               edge_n;
    logic             exp_valid;
    logic [OUT*W-1:0] exp_y;
    int               checks;
    int               errors;

    logic [OUT*W-1:0] ramp_y;
    logic [OUT*W-1:0] zero_y;
    logic [OUT*W-1:0] pmax_y;
    logic [OUT*W-1:0] nmin_y;

    // Reference model: the two-layer network in wide integer arithmetic.
    function automatic logic [OUT*W-1:0] model();
        longint s;
        longint h [HID];
        logic [OUT*W-1:0] y;
        y = '0;
        for (int j = 0; j < HID; j++) begin
            s = 0;
            for (int k = 0; k < IN; k++) s += longint'(x[k]) * longint'(w1[j][k]);
            h[j] = (s < 0) ? 0 : (s > 32767) ? 32767 : s;
        end
        for (int o = 0; o < OUT; o++) begin
            s = 0;
            for (int j = 0; j < HID; j++) s += h[j] * longint'(w2[o][j]);
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
            y[o*W +: W] = s[W-1:0];
        end
        return y;
    endfunction

    task automatic apply(input logic v);
        in_valid = v;
        for (int i = 0; i < IN; i++) inputs[i*W +: W] = x[i][W-1:0];
        for (int j = 0; j < HID; j++)
            for (int k = 0; k < IN; k++) weights1[(j*IN+k)*W +: W] = w1[j][k][W-1:0];
        for (int o = 0; o < OUT; o++)
            for (int j = 0; j < HID; j++) weights2[(o*HID+j)*W +: W] = w2[o][j][W-1:0];
    endtask

    // Advance one clock and update the model; return at the following negedge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            exp_valid = 1'b0;
            exp_y     = '0;
        end else begin
            edge_n++;
            if (in_valid) q.push_back('{edge_n + 1, model()});
            exp_valid = 1'b0;
            if (q.size() > 0 && q[0].due == edge_n) begin
                exp_valid = 1'b1;
                exp_y     = q[0].y;
                void'(q.pop_front());
            end
        end
        @(negedge clk);
    endtask

    task automatic set_ramp();
        for (int i = 0; i < IN; i++) x[i] = i + 1;
        for (int j = 0; j < HID; j++) for (int k = 0; k < IN; k++) w1[j][k] = k + 1;
        for (int o = 0; o < OUT; o++) for (int j = 0; j < HID; j++) w2[o][j] = j + 1;
    endtask

    task automatic set_relu();
        for (int i = 0; i < IN; i++) x[i] = (i == 0) ? -1 : 0;
        for (int j = 0; j < HID; j++) for (int k = 0; k < IN; k++) w1[j][k] = 1;
        for (int o = 0; o < OUT; o++) for (int j = 0; j < HID; j++) w2[o][j] = 1;
    endtask

    task automatic set_sat(input int w2v);
        for (int i = 0; i < IN; i++) x[i] = 1000;
        for (int j = 0; j < HID; j++) for (int k = 0; k < IN; k++) w1[j][k] = 1000;
        for (int o = 0; o < OUT; o++) for (int j = 0; j < HID; j++) w2[o][j] = w2v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < IN; i++) x[i] = 0;
        set_relu();
        apply(1'b0);
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        checks++;
        if (outputs !== zero_y) begin
            errors++;
            $display("FAIL reset_outputs: got %h want %h", outputs, zero_y);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_ramp();
        set_ramp();
        apply(1'b1);
        step();
        apply(1'b0);
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (out_valid !== (c == 2)) begin
                errors++;
                $display("FAIL ramp_latency c%0d: got valid %b want %b", c, out_valid, (c == 2));
            end
            if (c >= 2) begin
                checks++;
                if (outputs !== ramp_y) begin
                    errors++;
                    $display("FAIL ramp_value c%0d: got %h want %h", c, outputs, ramp_y);
                end
            end
            if (c < 3) step();
        end
    endtask

    task automatic test_relu();
        set_relu();
        apply(1'b1);
        step();
        apply(1'b0);
        step();
        checks++;
        if (out_valid !== 1'b1 || outputs !== zero_y) begin
            errors++;
            $display("FAIL relu: got valid %b out %h want 1 %h", out_valid, outputs, zero_y);
        end
    endtask

    task automatic test_saturation();
        set_sat(1);
        apply(1'b1);
        step();
        set_sat(-1000);
        apply(1'b1);
        step();
        apply(1'b0);
        checks++;
        if (out_valid !== 1'b1 || outputs !== pmax_y) begin
            errors++;
            $display("FAIL sat_pos: got valid %b out %h want 1 %h", out_valid, outputs, pmax_y);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || outputs !== nmin_y) begin
            errors++;
            $display("FAIL sat_neg: got valid %b out %h want 1 %h", out_valid, outputs, nmin_y);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [OUT*W-1:0] want [3];
        want[0] = ramp_y;
        want[1] = zero_y;
        want[2] = ramp_y;
        set_ramp();  apply(1'b1); step();
        set_relu();  apply(1'b1); step();
        set_ramp();  apply(1'b1); step();
        apply(1'b0);
        // The first result appeared at the previous negedge, so step back into alignment with a fresh vector stream check.
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (c == 0) begin
                if (out_valid !== 1'b1 || outputs !== want[1]) begin
                    errors++;
                    $display("FAIL b2b_stream c%0d: got valid %b out %h want 1 %h", c, out_valid, outputs, want[1]);
                end
            end else if (c == 1) begin
                if (out_valid !== 1'b1 || outputs !== want[2]) begin
                    errors++;
                    $display("FAIL b2b_stream c%0d: got valid %b out %h want 1 %h", c, out_valid, outputs, want[2]);
                end
            end else begin
                if (out_valid !== 1'b0 || outputs !== want[2]) begin
                    errors++;
                    $display("FAIL b2b_tail: got valid %b out %h want 0 %h", out_valid, outputs, want[2]);
                end
            end
            step();
        end
    endtask

    task automatic test_mid_reset();
        set_ramp();
        apply(1'b1);
        step();
        apply(1'b0);
        rst_n = 1'b0;
        #1;
        q.delete();
        exp_valid = 1'b0;
        exp_y     = '0;
        checks++;
        if (out_valid !== 1'b0 || outputs !== zero_y) begin
            errors++;
            $display("FAIL midreset_async: got valid %b out %h want 0 %h", out_valid, outputs, zero_y);
        end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_late_valid c%0d: got %b want 0", c, out_valid);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            bit big;
            big = ($urandom_range(3) == 0);
            for (int i = 0; i < IN; i++)
                x[i] = big ? int'($urandom_range(65535)) - 32768 : int'($urandom_range(100)) - 50;
            for (int j = 0; j < HID; j++) for (int k = 0; k < IN; k++)
                w1[j][k] = big ? int'($urandom_range(65535)) - 32768 : int'($urandom_range(100)) - 50;
            for (int o = 0; o < OUT; o++) for (int j = 0; j < HID; j++)
                w2[o][j] = big ? int'($urandom_range(65535)) - 32768 : int'($urandom_range(16)) - 8;
            apply($urandom_range(9) < 7);
            step();
            checks++;
            if (out_valid !== exp_valid) begin
                errors++;
                $display("FAIL rand_valid n%0d: got %b want %b", n, out_valid, exp_valid);
            end
            checks++;
            if (outputs !== exp_y) begin
                errors++;
                $display("FAIL rand_value n%0d: got %h want %h", n, outputs, exp_y);
            end
        end
        apply(1'b0);
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (out_valid !== exp_valid || outputs !== exp_y) begin
                errors++;
                $display("FAIL rand_drain c%0d: got %b %h want %b %h", c, out_valid, outputs, exp_valid, exp_y);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        edge_n    = 0;
        exp_valid = 1'b0;
        exp_y     = '0;
        in_valid  = 1'b0;
        inputs    = '0;
        weights1  = '0;
        weights2  = '0;
        ramp_y    = {OUT{16'd21175}};
        zero_y    = '0;
        pmax_y    = {OUT{16'h7FFF}};
        nmin_y    = {OUT{16'h8000}};
        test_reset();
        test_ramp();
        test_relu();
        test_saturation();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
